// File: rtl/dm_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_wait_responder
// Purpose  : Data-memory responder for the M-stage load/store initiator.
//            Accepts one request at a time over a req/ack handshake, inserts
//            WAIT wait states, then performs a word/half/byte access on an
//            internal 2**DEPTH_LOG2 x 32 memory. Loads return sign- or
//            zero-extended data with a one-cycle ack pulse. Misaligned
//            requests complete one cycle after acceptance with err=1.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous active-high; clears state and memory
//            req    - request valid, held by requester until ack
//            we     - 1 = store, 0 = load
//            mode   - access size: 0 word, 1 half, 2 byte, 3 word
//            sign   - 1 = sign-extend half/byte loads
//            addr   - byte address (upper bits alias)
//            wdata  - store data, right-aligned for half/byte
//            pc     - requesting instruction PC (store log only)
//            rdata  - load result, held until the next load ack
//            ack    - one-cycle completion pulse
//            err    - misalignment flag, pulses with ack
//            busy   - high from acceptance through the ack cycle
// Options  : define DM_LOG_EN to print every committed store in simulation.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wait_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  mode,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [2:0] c_wait_init = 3'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, r_wdata, r_pc;
  logic        r_we, r_sign;
  logic [1:0]  r_mode;
  logic [31:0] r_mem [DEPTH];

  logic        w_latch, w_do_access;
  logic [31:0] w_rdata_nxt;
  logic        w_ack_nxt, w_err_nxt, w_busy_nxt;

  // Access operands: in IDLE the request is taken straight from the ports
  // (WAIT==0 and misalignment are decided on the acceptance edge), later
  // from the latched copy.
  logic        w_idle;
  logic [31:0] w_a_addr, w_a_wdata, w_a_pc;
  logic        w_a_we, w_a_sign;
  logic [1:0]  w_a_mode;

  assign w_idle    = (r_state == S_IDLE);
  assign w_a_addr  = w_idle ? addr  : r_addr;
  assign w_a_wdata = w_idle ? wdata : r_wdata;
  assign w_a_pc    = w_idle ? pc    : r_pc;
  assign w_a_we    = w_idle ? we    : r_we;
  assign w_a_sign  = w_idle ? sign  : r_sign;
  assign w_a_mode  = w_idle ? mode  : r_mode;

  logic w_misaligned;
  always_comb begin
    w_misaligned = 1'b0;
    case (w_a_mode)
      2'd1:    w_misaligned = w_a_addr[0];
      2'd2:    w_misaligned = 1'b0;
      default: w_misaligned = (w_a_addr[1:0] != 2'b00);
    endcase
  end

  // Lane extraction and store merge on the addressed word.
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_word, w_merged, w_load, w_mask, w_ins;
  logic [4:0]            w_shamt;
  logic [31:0]           w_shifted;

  assign w_idx     = w_a_addr[DEPTH_LOG2+1:2];
  assign w_word    = r_mem[w_idx];
  assign w_shamt   = (w_a_mode == 2'd1) ? {w_a_addr[1], 4'b0000} : {w_a_addr[1:0], 3'b000};
  assign w_shifted = w_word >> w_shamt;

  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_ins  = w_a_wdata;
    w_load = w_word;
    case (w_a_mode)
      2'd1: begin
        w_mask = 32'h0000_FFFF << w_shamt;
        w_ins  = {16'h0000, w_a_wdata[15:0]} << w_shamt;
        w_load = {{16{w_a_sign & w_shifted[15]}}, w_shifted[15:0]};
      end
      2'd2: begin
        w_mask = 32'h0000_00FF << w_shamt;
        w_ins  = {24'h000000, w_a_wdata[7:0]} << w_shamt;
        w_load = {{24{w_a_sign & w_shifted[7]}}, w_shifted[7:0]};
      end
      default: ;
    endcase
  end

  assign w_merged = (w_word & ~w_mask) | w_ins;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_do_access = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = busy;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (req) begin
          w_latch    = 1'b1;
          w_busy_nxt = 1'b1;
          if (w_misaligned) begin
            w_state_nxt = S_RESP;
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (WAIT == 0) begin
            w_do_access = 1'b1;
            w_state_nxt = S_RESP;
            w_ack_nxt   = 1'b1;
          end else begin
            w_cnt_nxt   = c_wait_init;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Access on the edge where the counter reaches 1 so that ack is
        // visible WAIT+1 cycles counting the acceptance cycle as the first.
        if (r_cnt <= 3'd1) begin
          w_do_access = 1'b1;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_RESP;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign w_rdata_nxt = (w_do_access && !w_a_we) ? w_load : rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_pc    <= 32'd0;
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_mode  <= 2'd0;
      rdata   <= 32'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_pc    <= pc;
        r_we    <= we;
        r_sign  <= sign;
        r_mode  <= mode;
      end
      rdata <= w_rdata_nxt;
      ack   <= w_ack_nxt;
      err   <= w_err_nxt;
      busy  <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_do_access && w_a_we) begin
      r_mem[w_idx] <= w_merged;
`ifdef DM_LOG_EN
      $display("@%h: *%h <= %h", w_a_pc, {w_a_addr[31:2], 2'b00}, w_merged);
`endif
    end
  end

  // Upper address bits alias by design; pc only feeds the optional log.
  logic w_unused;
  assign w_unused = ^{1'b0, w_a_addr, w_a_pc};

endmodule
`default_nettype wire
